ccd_pixel_tx: RTL

Transmit-side stage between the CCD readout controller and the FT232H FT245 synchronous FIFO bus. It buffers 16-bit AD9826 pixel words and frame markers in an internal FIFO, then serializes them MSB-byte-first onto the FT245 write interface under `ft_txe_n` flow control. It sits in the `ft_clkout` clock domain, and a bus arbiter shares `ft_bus` with the command receive path. At frame end it issues a send-immediate pulse so the host gets the frame tail without waiting for the USB packet timeout.

---
 rtl/ccd_pkg.sv | 9 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/ccd_pixel_tx.sv | 100 ++++++++++
 3 files changed

// File: rtl/ccd_pkg.sv
// ccd_pkg: shared constants, serializer states and byte helper for the CCD pixel transmit path.
package ccd_pkg;
  localparam logic [15:0] SYNC_DEFAULT = 16'hA55A;
  localparam int TAG = 16;
  typedef enum logic [2:0] {IDLE, LOAD, M_HI, M_LO, M_ID, P_HI, P_LO, SIWU} state_t;
  function automatic logic [7:0] first_byte(input logic [16:0] e, input logic [15:0] sync);
    return e[TAG] ? sync[15:8] : e[15:8];
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and occupancy level.
module sync_fifo #(
  parameter int W   = 17,
  parameter int DL2 = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [W-1:0]   wr_data,
  input  logic           rd_en,
  output logic [W-1:0]   rd_data,
  output logic           full,
  output logic           empty,
  output logic [DL2:0]   level
);
  logic [W-1:0] mem [2**DL2];
  logic [DL2-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DL2:0] lvl_q, lvl_d;
  logic [W-1:0] rd_q, rd_d;
  logic we, re;
  // a write into a full FIFO is legal when a pop happens on the same edge
  always_comb begin
    full = lvl_q[DL2];
    empty = lvl_q == '0;
    re = rd_en & !empty;
    we = wr_en & (!full | re);
    wp_d = wp_q + DL2'(we);
    rp_d = rp_q + DL2'(re);
    lvl_d = lvl_q + (DL2+1)'(we) - (DL2+1)'(re);
    rd_d = re ? mem[rp_q] : rd_q;
    rd_data = rd_q;
    level = lvl_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      lvl_q <= '0;
      rd_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      lvl_q <= lvl_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (we) mem[wp_q] <= wr_data;
endmodule

// File: rtl/ccd_pixel_tx.sv
// ccd_pixel_tx: buffers pixels/frame markers and serializes them MSB-first onto the FT245 write bus.
module ccd_pixel_tx import ccd_pkg::*; #(
  parameter int          DEPTH_LOG2 = 9,
  parameter logic [15:0] SYNC_WORD  = SYNC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  input  logic [15:0]           pix_data,
  output logic                  pix_ready,
  input  logic                  frame_start,
  input  logic [7:0]            frame_id,
  input  logic                  frame_end,
  output logic                  bus_req,
  input  logic                  bus_grant,
  input  logic                  ft_txe_n,
  output logic                  ft_wr_n,
  output logic [7:0]            ft_data_out,
  output logic                  ft_siwu_n,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  input  logic                  clr_overflow
);
  state_t st_q, st_d;
  logic full, empty, wr_en, rd_en, acc;
  logic [16:0] head, wr_data;
  logic pf_q, pf_d, flush_q, flush_d, ovf_q, ovf_d, wr_n_q, wr_n_d, siwu_n_q, siwu_n_d;
  logic [7:0] dat_q, dat_d;
  sync_fifo #(.W(17), .DL2(DEPTH_LOG2)) u_fifo (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(head), .full(full), .empty(empty), .level(fifo_level)
  );
  // pf_q: the FIFO read register already holds the next entry, popped during the final byte
  always_comb begin
    acc = !wr_n_q & !ft_txe_n;
    st_d = st_q;
    pf_d = pf_q;
    dat_d = dat_q;
    rd_en = 1'b0;
    case (st_q)
      IDLE: begin
        rd_en = !empty;
        st_d = !empty ? LOAD : flush_q ? SIWU : IDLE;
      end
      LOAD: begin
        st_d = head[TAG] ? M_HI : P_HI;
        dat_d = first_byte(head, SYNC_WORD);
      end
      M_HI: if (acc) begin
        st_d = M_LO;
        dat_d = SYNC_WORD[7:0];
      end
      M_LO, P_HI: if (acc) begin
        st_d = st_q == M_LO ? M_ID : P_LO;
        dat_d = head[7:0];
        rd_en = !empty;
        pf_d = !empty;
      end
      M_ID, P_LO: begin
        rd_en = !empty & !pf_q;
        pf_d = acc ? 1'b0 : pf_q | rd_en;
        if (acc) begin
          st_d = pf_q ? (head[TAG] ? M_HI : P_HI) : !empty ? LOAD : flush_q ? SIWU : IDLE;
          dat_d = pf_q ? first_byte(head, SYNC_WORD) : dat_q;
        end
      end
      default: st_d = IDLE;
    endcase
    pix_ready = !full & !frame_start;
    wr_en = frame_start | (pix_valid & pix_ready);
    wr_data = frame_start ? {1'b1, 8'h00, frame_id} : {1'b0, pix_data};
    ovf_d = (full & frame_start & !rd_en) | (full & pix_valid & !frame_start) | (ovf_q & !clr_overflow);
    flush_d = frame_end | (flush_q & st_q != SIWU);
    wr_n_d = !(bus_grant & (st_d inside {M_HI, M_LO, M_ID, P_HI, P_LO}));
    siwu_n_d = st_d != SIWU;
    bus_req = st_q != IDLE | !empty;
    ft_wr_n = wr_n_q;
    ft_data_out = dat_q;
    ft_siwu_n = siwu_n_q;
    overflow = ovf_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= IDLE;
      pf_q <= 1'b0;
      flush_q <= 1'b0;
      ovf_q <= 1'b0;
      wr_n_q <= 1'b1;
      siwu_n_q <= 1'b1;
      dat_q <= 8'h00;
    end else begin
      st_q <= st_d;
      pf_q <= pf_d;
      flush_q <= flush_d;
      ovf_q <= ovf_d;
      wr_n_q <= wr_n_d;
      siwu_n_q <= siwu_n_d;
      dat_q <= dat_d;
    end
endmodule
